// File: rtl/ook_bit_serializer.sv
// ook_bit_serializer
//   Byte-to-bit on/off-keying source for the OOK DDS ook_data input.
//   Bytes arrive on a valid/ready interface. They are sent MSB-first, and each
//   bit lasts CLKS_PER_BIT clocks. Back-to-back bytes leave no gap, and an idle
//   line keys the carrier off.
//   Optional feature macro: OOK_PREAMBLE_EN. When it is defined, the first byte
//   of each burst is preceded by the 8-bit PREAMBLE pattern.
//   Reset is synchronous and active-high.
module ook_bit_serializer #(
    parameter int         CLKS_PER_BIT = 1000
`ifdef OOK_PREAMBLE_EN
    ,
    parameter logic [7:0] PREAMBLE     = 8'hAA
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       ook_data,
    output logic       busy,
    output logic       bit_strobe,
    output logic       done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef OOK_PREAMBLE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DATA} state_t;
`endif

    state_t             state,      state_nxt;
    logic [7:0]         shift_reg,  shift_nxt;   // current bit always sits in [7]
    logic [2:0]         bit_idx,    bit_idx_nxt;
    logic [CNT_W-1:0]   clk_cnt,    clk_cnt_nxt;
    logic               ook_nxt, busy_nxt, strobe_nxt, done_nxt;
`ifdef OOK_PREAMBLE_EN
    logic [7:0]         data_reg,   data_nxt;    // payload parked while the preamble goes out
`endif

    logic bit_wrap;
    logic last_cycle;
    logic handshake;

    assign bit_wrap   = (clk_cnt == CNT_LAST);
    assign last_cycle = (state == ST_DATA) && (bit_idx == 3'd7) && bit_wrap;
    assign s_ready    = !rst && ((state == ST_IDLE) || last_cycle);
    assign handshake  = s_valid && s_ready;

    // Next-state and next-output decode for the serializer FSM
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        clk_cnt_nxt = clk_cnt;
        ook_nxt     = ook_data;
        busy_nxt    = busy;
        strobe_nxt  = 1'b0;
        done_nxt    = 1'b0;
`ifdef OOK_PREAMBLE_EN
        data_nxt    = data_reg;
`endif

        case (state)
            ST_IDLE: begin
                if (handshake) begin
`ifdef OOK_PREAMBLE_EN
                    state_nxt = ST_PRE;
                    shift_nxt = PREAMBLE;
                    data_nxt  = s_data;
                    ook_nxt   = PREAMBLE[7];
`else
                    state_nxt = ST_DATA;
                    shift_nxt = s_data;
                    ook_nxt   = s_data[7];
`endif
                    bit_idx_nxt = 3'd0;
                    clk_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    strobe_nxt  = 1'b1;
                end
            end

`ifdef OOK_PREAMBLE_EN
            ST_PRE: begin
                if (!bit_wrap) begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end else begin
                    clk_cnt_nxt = '0;
                    strobe_nxt  = 1'b1;
                    if (bit_idx == 3'd7) begin
                        // Preamble finished: payload MSB follows without a gap
                        state_nxt   = ST_DATA;
                        shift_nxt   = data_reg;
                        ook_nxt     = data_reg[7];
                        bit_idx_nxt = 3'd0;
                    end else begin
                        shift_nxt   = {shift_reg[6:0], 1'b0};
                        ook_nxt     = shift_reg[6];
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`endif

            ST_DATA: begin
                if (!bit_wrap) begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end else if (bit_idx != 3'd7) begin
                    clk_cnt_nxt = '0;
                    strobe_nxt  = 1'b1;
                    shift_nxt   = {shift_reg[6:0], 1'b0};
                    ook_nxt     = shift_reg[6];
                    bit_idx_nxt = bit_idx + 3'd1;
                end else if (handshake) begin
                    // Chained byte: no preamble, no done, MSB on the next cycle
                    clk_cnt_nxt = '0;
                    strobe_nxt  = 1'b1;
                    shift_nxt   = s_data;
                    ook_nxt     = s_data[7];
                    bit_idx_nxt = 3'd0;
                end else begin
                    // Burst over: key off and return to idle
                    state_nxt   = ST_IDLE;
                    shift_nxt   = 8'h00;
                    bit_idx_nxt = 3'd0;
                    clk_cnt_nxt = '0;
                    ook_nxt     = 1'b0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register
        // samples pre-edge values, whatever order the statements are in.
        if (rst) begin
            // NOTE: reset is synchronous. It clears every register here because
            // there is no memory array that would need to stay un-reset.
            state      <= ST_IDLE;
            shift_reg  <= 8'h00;
            bit_idx    <= 3'd0;
            clk_cnt    <= '0;
            ook_data   <= 1'b0;
            busy       <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
`ifdef OOK_PREAMBLE_EN
            data_reg   <= 8'h00;
`endif
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            clk_cnt    <= clk_cnt_nxt;
            ook_data   <= ook_nxt;
            busy       <= busy_nxt;
            bit_strobe <= strobe_nxt;
            done       <= done_nxt;
`ifdef OOK_PREAMBLE_EN
            data_reg   <= data_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ook_bit_serializer.sv
// tb_ook_bit_serializer
//   Scoreboard bench for ook_bit_serializer with CLKS_PER_BIT=4.
//   The driver pushes the expected bit timeline for every accepted byte. The
//   negedge monitor pops the queue and compares ook_data, bit_strobe, busy,
//   done and s_ready on every cycle.
module tb_ook_bit_serializer;

    localparam int CPB = 4;
`ifdef OOK_PREAMBLE_EN
    localparam int FIRST_BITS = 16;
`else
    localparam int FIRST_BITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, ook_data, busy, bit_strobe, done;

    ook_bit_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ook_data   (ook_data),
        .busy       (busy),
        .bit_strobe (bit_strobe),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected bit timeline: value and the cycle on which it must start
    typedef struct {
        int   t;
        logic b;
    } exp_bit_t;

    exp_bit_t sb_q[$];
    int   last_end    = -100;     // last cycle of the current burst
    int   burst_start = 1 << 30;  // first cycle of the current burst
    logic cur_bit     = 1'b0;
    int   strobe_cnt  = 0;
    int   done_cnt    = 0;
    int   last_done   = -1;

    // Reference model: one accepted byte extends or starts a burst
    function automatic void model_accept(input logic [7:0] b, input int t);
        logic [7:0] pre;
        int  start;
        int  n;
        bit  cont;
        pre   = 8'hAA;
        cont  = (t == last_end);
        start = t + 1;
        n     = 0;
        if (!cont) burst_start = start;
`ifdef OOK_PREAMBLE_EN
        if (!cont) begin
            for (int k = 7; k >= 0; k--) begin
                sb_q.push_back('{t: start + n * CPB, b: pre[k]});
                n++;
            end
        end
`else
        if (pre == 8'h00) n = 0;
`endif
        for (int k = 7; k >= 0; k--) begin
            sb_q.push_back('{t: start + n * CPB, b: b[k]});
            n++;
        end
        last_end = start + n * CPB - 1;
    endfunction

    function automatic void model_reset();
        sb_q.delete();
        last_end    = -100;
        burst_start = 1 << 30;
        cur_bit     = 1'b0;
    endfunction

    // Monitor: compare every output against the model on each falling edge
    always @(negedge clk) begin : monitor
        logic exp_strobe, exp_busy, exp_done, exp_ready;
        exp_bit_t e;
        exp_strobe = (sb_q.size() > 0) && (sb_q[0].t == cyc);
        if (exp_strobe) begin
            e = sb_q.pop_front();
            cur_bit = e.b;
        end
        exp_busy  = (cyc >= burst_start) && (cyc <= last_end);
        exp_done  = (cyc == last_end + 1);
        exp_ready = !rst && (!exp_busy || (cyc == last_end));
        if (!exp_busy) cur_bit = 1'b0;
        if (bit_strobe) strobe_cnt++;
        if (done) begin
            done_cnt++;
            last_done = cyc;
        end
        check("bit_strobe", bit_strobe, exp_strobe);
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("ook_data", ook_data, cur_bit);
        check("s_ready", s_ready, exp_ready);
    end

    // Drive one byte and hold it until accepted; returns the handshake cycle
    task automatic send_byte(input logic [7:0] b, output int t_hs);
        bit ok;
        ok     = 1'b0;
        t_hs   = -1;
        s_data = b;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (s_ready && !rst) begin
                t_hs = cyc;
                model_accept(b, cyc);
                ok = 1'b1;
                break;
            end
        end
        #1;
        s_valid = 1'b0;
        check("handshake_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && cyc > last_end + 1) break;
        end
        check("idle_queue_empty", sb_q.size(), 0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t1, t2, t3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s_ready", s_ready, 1'b0);
        check("reset_ook", ook_data, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_s_ready", s_ready, 1'b1);

        // 0xA5 from idle
        strobe_cnt = 0; done_cnt = 0;
        send_byte(8'hA5, t1);
        wait_idle();
        check("a5_strobes", strobe_cnt, FIRST_BITS);
        check("a5_done_cycle", last_done, t1 + FIRST_BITS * CPB + 1);
        check("a5_done_count", done_cnt, 1);

        // 0xFF then 0x00 back-to-back
        strobe_cnt = 0; done_cnt = 0;
        send_byte(8'hFF, t1);
        send_byte(8'h00, t2);
        check("ff00_chain_cycle", t2 - t1, FIRST_BITS * CPB);
        wait_idle();
        check("ff00_done_count", done_cnt, 1);
        check("ff00_done_cycle", last_done, t1 + (FIRST_BITS + 8) * CPB + 1);

        // 0x3C held while busy
        send_byte(8'h5A, t1);
        send_byte(8'h3C, t2);
        check("3c_wait_cycle", t2 - t1, FIRST_BITS * CPB);
        wait_idle();

        // Reset in the middle of 0xF0
        done_cnt = 0;
        send_byte(8'hF0, t1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ook", ook_data, 1'b0);
        check("rst_mid_done", done_cnt, 0);
        @(posedge clk);
        #1;
        strobe_cnt = 0;
        send_byte(8'h81, t3);
        wait_idle();
        check("81_strobes", strobe_cnt, FIRST_BITS);

        // 0x00: busy with the carrier off
        strobe_cnt = 0;
        send_byte(8'h00, t1);
        wait_idle();
        check("00_strobes", strobe_cnt, FIRST_BITS);
        check("00_done_cycle", last_done, t1 + FIRST_BITS * CPB + 1);

        // Random bytes with random gaps, including chained transfers
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
            send_byte(8'($urandom), t1);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
